// File: rtl/quant_multichannel.sv
// rtl/quant_multichannel.sv - per-channel scaled int-to-int quantizer with serial scale calibration

module quant_multichannel #(
   parameter int IN_W       = 32,
   parameter int OUT_W      = 8,
   parameter int NUM_CH     = 4,
   parameter int SCALE_FRAC = 24,
   parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cal_start,
   input  logic [CH_W-1:0]   cal_ch,
   input  logic [31:0]       cal_max_abs,
   output logic              cal_busy,
   output logic              cal_done,
   output logic              cal_err,
   output logic [NUM_CH-1:0] ch_calibrated,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_data,
   input  logic [CH_W-1:0]   in_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic [31:0]       dbg_scale
);

   localparam int DIV_W  = OUT_W - 1 + SCALE_FRAC;
   localparam int CNT_W  = $clog2(DIV_W + 1);
   localparam int PROD_W = IN_W + 33;

   // QMAX << SCALE_FRAC: QMAX is all ones in OUT_W-1 bits
   localparam logic [DIV_W-1:0] DIVIDEND = {{(OUT_W-1){1'b1}}, {SCALE_FRAC{1'b0}}};
   localparam logic signed [PROD_W-1:0] QMAX_P  = PROD_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [PROD_W-1:0] QMIN_P  = -QMAX_P;
   localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(1) <<< (SCALE_FRAC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_WRITE
   } cal_state_t;

   cal_state_t state, state_nxt;

   logic [31:0]       scale_tab [NUM_CH];
   logic [31:0]       div_den;
   logic [DIV_W-1:0]  div_num;
   logic [31:0]       div_rem;
   logic [CNT_W-1:0]  div_cnt;
   logic [CH_W-1:0]   cal_ch_q;
   logic              cal_err_q;
   logic              cal_ch_ok;
   logic              in_ch_ok;
   logic              req_ok;
   logic              cal_accept;

   logic [32:0]       rem_shift;
   logic [32:0]       rem_sub;
   logic              q_bit;

   logic              advance;
   logic [31:0]       sample_scale;
   logic signed [PROD_W-1:0] mul_a;
   logic signed [PROD_W-1:0] mul_b;
   logic signed [PROD_W-1:0] mul_p;

   logic              s1_valid;
   logic signed [PROD_W-1:0] s1_prod;
   logic [CH_W-1:0]   s1_ch;

   logic signed [PROD_W-1:0] rnd_sum;
   logic signed [PROD_W-1:0] rnd_shift;
   logic [OUT_W-1:0]  sat_data;

   // Channel range checks collapse to constant 1 when every index value is a real channel
   if (NUM_CH == (1 << CH_W)) begin : g_full_range
      assign cal_ch_ok = 1'b1;
      assign in_ch_ok  = 1'b1;
   end else begin : g_part_range
      assign cal_ch_ok = (cal_ch < CH_W'(NUM_CH));
      assign in_ch_ok  = (in_ch < CH_W'(NUM_CH));
   end

   assign req_ok = cal_ch_ok && (cal_max_abs != 32'd0);

   // Calibration state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Calibration next-state and status outputs
   always_comb begin
      state_nxt  = state;
      cal_accept = 1'b0;
      cal_busy   = 1'b0;
      cal_done   = 1'b0;
      case (state)
         S_IDLE: begin
            if (cal_start && req_ok) begin
               cal_accept = 1'b1;
               state_nxt  = S_DIV;
            end
         end
         S_DIV: begin
            cal_busy = 1'b1;
            if (div_cnt == CNT_W'(DIV_W - 1)) begin
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            cal_busy  = 1'b1;
            cal_done  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // One restoring-division step; the remainder stays below the divisor, so
   // bit 32 of the trial difference is set exactly when the subtraction borrows
   always_comb begin
      rem_shift = {div_rem, div_num[DIV_W-1]};
      rem_sub   = rem_shift - {1'b0, div_den};
      q_bit     = ~rem_sub[32];
   end

   // Divider registers: dividend bits shift out the top as quotient bits shift in
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_den  <= '0;
         div_num  <= '0;
         div_rem  <= '0;
         div_cnt  <= '0;
         cal_ch_q <= '0;
      end else if (cal_accept) begin
         div_den  <= cal_max_abs;
         div_num  <= DIVIDEND;
         div_rem  <= '0;
         div_cnt  <= '0;
         cal_ch_q <= cal_ch;
      end else if (state == S_DIV) begin
         div_num <= {div_num[DIV_W-2:0], q_bit};
         div_rem <= q_bit ? rem_sub[31:0] : rem_shift[31:0];
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Rejected request flag, visible for one cycle after the start pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cal_err_q <= 1'b0;
      end else begin
         cal_err_q <= (state == S_IDLE) && cal_start && !req_ok;
      end
   end

   assign cal_err = cal_err_q;

   // Scale table and valid flags, written only from the WRITE state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            scale_tab[i] <= '0;
         end
         ch_calibrated <= '0;
      end else if (state == S_WRITE) begin
         scale_tab[cal_ch_q]     <= 32'(div_num);
         ch_calibrated[cal_ch_q] <= 1'b1;
      end
   end

   // Combinational table reads for debug and for the incoming sample
   always_comb begin
      dbg_scale    = '0;
      sample_scale = '0;
      if (cal_ch_ok) begin
         dbg_scale = scale_tab[cal_ch];
      end
      if (in_ch_ok) begin
         sample_scale = scale_tab[in_ch];
      end
   end

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Stage 1 multiply: signed sample times zero-extended unsigned scale
   always_comb begin
      mul_a = PROD_W'($signed(in_data));
      mul_b = $signed(PROD_W'(sample_scale));
      mul_p = mul_a * mul_b;
   end

   // Stage 2 round-half-up, drop fraction bits, clamp to symmetric range
   always_comb begin
      rnd_sum   = s1_prod + ROUND_C;
      rnd_shift = rnd_sum >>> SCALE_FRAC;
      if (rnd_shift > QMAX_P) begin
         sat_data = QMAX_P[OUT_W-1:0];
      end else if (rnd_shift < QMIN_P) begin
         sat_data = QMIN_P[OUT_W-1:0];
      end else begin
         sat_data = rnd_shift[OUT_W-1:0];
      end
   end

   // Two-stage pipeline; both stages move together on advance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_prod   <= '0;
         s1_ch     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (in_valid) begin
            s1_prod <= mul_p;
            s1_ch   <= in_ch;
         end
         if (s1_valid) begin
            out_data <= sat_data;
            out_ch   <= s1_ch;
         end
      end
   end

endmodule

// File: tb/tb_quant_multichannel.sv
// tb/tb_quant_multichannel.sv - randomized self-checking bench for quant_multichannel

module tb_quant_multichannel;

   localparam int IN_W       = 32;
   localparam int OUT_W      = 8;
   localparam int NUM_CH     = 4;
   localparam int SCALE_FRAC = 24;
   localparam int CH_W       = 2;
   localparam longint QMAX   = 127;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n;
   logic              cal_start;
   logic [CH_W-1:0]   cal_ch;
   logic [31:0]       cal_max_abs;
   logic              cal_busy, cal_done, cal_err;
   logic [NUM_CH-1:0] ch_calibrated;
   logic              in_valid, in_ready;
   logic [IN_W-1:0]   in_data;
   logic [CH_W-1:0]   in_ch;
   logic              out_valid, out_ready;
   logic [OUT_W-1:0]  out_data;
   logic [CH_W-1:0]   out_ch;
   logic [31:0]       dbg_scale;

   logic              cal_start_5;
   logic [2:0]        cal_ch_5;
   logic [31:0]       cal_max_abs_5;
   logic              cal_busy_5, cal_done_5, cal_err_5;
   logic [4:0]        ch_calibrated_5;
   logic              in_valid_5, in_ready_5;
   logic [IN_W-1:0]   in_data_5;
   logic [2:0]        in_ch_5;
   logic              out_valid_5, out_ready_5;
   logic [OUT_W-1:0]  out_data_5;
   logic [2:0]        out_ch_5;
   logic [31:0]       dbg_scale_5;

   quant_multichannel dut (
      .clk(clk), .reset_n(reset_n),
      .cal_start(cal_start), .cal_ch(cal_ch), .cal_max_abs(cal_max_abs),
      .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err),
      .ch_calibrated(ch_calibrated),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
      .dbg_scale(dbg_scale)
   );

   quant_multichannel #(.NUM_CH(5)) dut5 (
      .clk(clk), .reset_n(reset_n),
      .cal_start(cal_start_5), .cal_ch(cal_ch_5), .cal_max_abs(cal_max_abs_5),
      .cal_busy(cal_busy_5), .cal_done(cal_done_5), .cal_err(cal_err_5),
      .ch_calibrated(ch_calibrated_5),
      .in_valid(in_valid_5), .in_ready(in_ready_5), .in_data(in_data_5), .in_ch(in_ch_5),
      .out_valid(out_valid_5), .out_ready(out_ready_5), .out_data(out_data_5), .out_ch(out_ch_5),
      .dbg_scale(dbg_scale_5)
   );

   int checks   = 0;
   int failures = 0;

   longint model_scale [NUM_CH];
   bit     model_cal   [NUM_CH];

   int st_data[$];
   int st_ch[$];
   bit st_rdy[$];
   int ob_data[$];
   int ob_ch[$];
   int ob_cyc[$];
   int acc_cyc[$];
   int hold_err;
   int stall_cycles;

   function automatic longint ref_scale(input longint m);
      return (QMAX << SCALE_FRAC) / m;
   endfunction

   function automatic int ref_quant(input int d, input int ch);
      longint p, r;
      p = longint'(d) * model_scale[ch];
      r = (p + (longint'(1) << (SCALE_FRAC - 1))) >>> SCALE_FRAC;
      if (r > QMAX)  r = QMAX;
      if (r < -QMAX) r = -QMAX;
      return int'(r);
   endfunction

   function automatic logic [NUM_CH-1:0] model_flags();
      logic [NUM_CH-1:0] f;
      for (int i = 0; i < NUM_CH; i++) f[i] = model_cal[i];
      return f;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NUM_CH; i++) begin
         model_scale[i] = 0;
         model_cal[i]   = 1'b0;
      end
   endtask

   task automatic do_cal(input int ch, input logic [31:0] mx, output int n, output bit err_seen);
      @(negedge clk);
      cal_start = 1'b1; cal_ch = CH_W'(ch); cal_max_abs = mx; err_seen = 1'b0;
      @(posedge clk); n = 1;
      @(negedge clk); cal_start = 1'b0;
      while (!cal_done && n < 200) begin
         if (cal_err) err_seen = 1'b1;
         @(posedge clk); n++;
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_stream(input int budget);
      int idx, n, cyc;
      bit prev_hold;
      logic [OUT_W-1:0] prev_d;
      logic [CH_W-1:0]  prev_c;
      ob_data.delete(); ob_ch.delete(); ob_cyc.delete(); acc_cyc.delete();
      hold_err = 0; stall_cycles = 0;
      n = st_data.size(); idx = 0; cyc = 0; prev_hold = 1'b0; prev_d = '0; prev_c = '0;
      while ((ob_data.size() < n) && (cyc < budget)) begin
         @(negedge clk);
         in_valid  = (idx < n);
         in_data   = (idx < n) ? st_data[idx] : 0;
         in_ch     = (idx < n) ? CH_W'(st_ch[idx]) : '0;
         out_ready = (cyc < st_rdy.size()) ? st_rdy[cyc] : 1'b1;
         #1;
         if (prev_hold && (!out_valid || out_data !== prev_d || out_ch !== prev_c)) hold_err++;
         if (in_valid && in_ready) begin
            acc_cyc.push_back(cyc);
            idx++;
         end else if (in_valid) begin
            stall_cycles++;
         end
         if (out_valid && out_ready) begin
            ob_data.push_back(int'($signed(out_data)));
            ob_ch.push_back(int'(out_ch));
            ob_cyc.push_back(cyc);
         end
         prev_hold = out_valid && !out_ready;
         prev_d = out_data; prev_c = out_ch;
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      checks++; if (cal_busy !== 1'b0) begin failures++; $display("FAIL reset_cal_busy: got %0b expected 0", cal_busy); end
      checks++; if (cal_done !== 1'b0) begin failures++; $display("FAIL reset_cal_done: got %0b expected 0", cal_done); end
      checks++; if (cal_err !== 1'b0) begin failures++; $display("FAIL reset_cal_err: got %0b expected 0", cal_err); end
      checks++; if (ch_calibrated !== '0) begin failures++; $display("FAIL reset_flags: got %b expected 0", ch_calibrated); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++; if (out_data !== '0 || out_ch !== '0) begin failures++; $display("FAIL reset_out_data: got %0d/%0d expected 0/0", out_data, out_ch); end
      checks++; if (dbg_scale !== 32'd0) begin failures++; $display("FAIL reset_scale: got %0d expected 0", dbg_scale); end
      repeat (3) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      clear_model();
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_calibrate_ch0();
      int n; bit e;
      do_cal(0, 32'd1270, n, e);
      model_scale[0] = ref_scale(1270); model_cal[0] = 1'b1;
      checks++; if (n !== 32) begin failures++; $display("FAIL cal0_latency: got %0d expected 32", n); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL cal0_err: got %0b expected 0", e); end
      checks++; if (dbg_scale !== 32'(model_scale[0])) begin failures++; $display("FAIL cal0_scale: got %0d expected %0d", dbg_scale, model_scale[0]); end
      checks++; if (ch_calibrated !== model_flags()) begin failures++; $display("FAIL cal0_flags: got %b expected %b", ch_calibrated, model_flags()); end
   endtask

   task automatic check_stream(input string name);
      int n, e;
      n = st_data.size();
      checks++; if (ob_data.size() !== n) begin failures++; $display("FAIL %s_count: got %0d expected %0d", name, ob_data.size(), n); end
      for (int i = 0; i < n && i < ob_data.size(); i++) begin
         e = ref_quant(st_data[i], st_ch[i]);
         checks++; if (ob_data[i] !== e) begin failures++; $display("FAIL %s_data[%0d]: got %0d expected %0d", name, i, ob_data[i], e); end
         checks++; if (ob_ch[i] !== st_ch[i]) begin failures++; $display("FAIL %s_ch[%0d]: got %0d expected %0d", name, i, ob_ch[i], st_ch[i]); end
      end
   endtask

   task automatic test_stream_basic();
      st_data = '{1270, -1270, 635, 0}; st_ch = '{0, 0, 0, 0}; st_rdy.delete();
      run_stream(50);
      check_stream("basic");
      for (int i = 0; i < 4 && i < ob_cyc.size() && i < acc_cyc.size(); i++) begin
         checks++; if (acc_cyc[i] !== i) begin failures++; $display("FAIL basic_accept[%0d]: got cycle %0d expected %0d", i, acc_cyc[i], i); end
         checks++; if (ob_cyc[i] - acc_cyc[i] !== 2) begin failures++; $display("FAIL basic_latency[%0d]: got %0d expected 2", i, ob_cyc[i] - acc_cyc[i]); end
      end
   endtask

   task automatic test_saturation();
      st_data = '{100000, -100000, int'(32'h8000_0000), 2147483647}; st_ch = '{0, 0, 0, 0}; st_rdy.delete();
      run_stream(50);
      check_stream("sat");
   endtask

   task automatic test_interleave_ch1();
      int n; bit e;
      do_cal(1, 32'd1, n, e);
      model_scale[1] = ref_scale(1); model_cal[1] = 1'b1;
      checks++; if (dbg_scale !== 32'(model_scale[1])) begin failures++; $display("FAIL cal1_scale: got %0d expected %0d", dbg_scale, model_scale[1]); end
      checks++; if (ch_calibrated !== model_flags()) begin failures++; $display("FAIL cal1_flags: got %b expected %b", ch_calibrated, model_flags()); end
      st_data = '{1, 1, 1, 1, 1, 1}; st_ch = '{0, 1, 0, 1, 1, 0}; st_rdy.delete();
      run_stream(50);
      check_stream("interleave");
   endtask

   task automatic test_cal_errors();
      int n; bit e;
      @(negedge clk); cal_start = 1'b1; cal_ch = 2'd2; cal_max_abs = 32'd0;
      @(posedge clk);
      @(negedge clk); cal_start = 1'b0;
      checks++; if (cal_err !== 1'b1) begin failures++; $display("FAIL zero_err_pulse: got %0b expected 1", cal_err); end
      checks++; if (cal_busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %0b expected 0", cal_busy); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (cal_err !== 1'b0) begin failures++; $display("FAIL zero_err_width: got %0b expected 0", cal_err); end
      checks++; if (ch_calibrated !== model_flags()) begin failures++; $display("FAIL zero_flags: got %b expected %b", ch_calibrated, model_flags()); end
      checks++; if (dbg_scale !== 32'd0) begin failures++; $display("FAIL zero_scale: got %0d expected 0", dbg_scale); end

      e = 1'b0;
      cal_start = 1'b1; cal_ch = 2'd2; cal_max_abs = 32'd1000;
      @(posedge clk); n = 1;
      @(negedge clk); cal_start = 1'b0;
      repeat (5) begin @(posedge clk); n++; end
      @(negedge clk); cal_start = 1'b1; cal_ch = 2'd3; cal_max_abs = 32'd1;
      @(posedge clk); n++;
      @(negedge clk); cal_start = 1'b0; cal_ch = 2'd2; cal_max_abs = 32'd1000;
      while (!cal_done && n < 200) begin
         if (cal_err) e = 1'b1;
         @(posedge clk); n++;
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      model_scale[2] = ref_scale(1000); model_cal[2] = 1'b1;
      checks++; if (n !== 32) begin failures++; $display("FAIL busy_start_latency: got %0d expected 32", n); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL busy_start_err: got %0b expected 0", e); end
      checks++; if (dbg_scale !== 32'(model_scale[2])) begin failures++; $display("FAIL busy_start_scale: got %0d expected %0d", dbg_scale, model_scale[2]); end
      checks++; if (ch_calibrated !== model_flags()) begin failures++; $display("FAIL busy_start_flags: got %b expected %b", ch_calibrated, model_flags()); end
      cal_ch = 2'd3;
      #1;
      checks++; if (dbg_scale !== 32'd0) begin failures++; $display("FAIL busy_start_ch3: got %0d expected 0", dbg_scale); end
   endtask

   task automatic test_bad_channel();
      int n;
      @(negedge clk); cal_start_5 = 1'b1; cal_ch_5 = 3'd5; cal_max_abs_5 = 32'd100;
      @(posedge clk);
      @(negedge clk); cal_start_5 = 1'b0;
      checks++; if (cal_err_5 !== 1'b1) begin failures++; $display("FAIL badch_err: got %0b expected 1", cal_err_5); end
      checks++; if (cal_busy_5 !== 1'b0) begin failures++; $display("FAIL badch_busy: got %0b expected 0", cal_busy_5); end
      checks++; if (ch_calibrated_5 !== 5'b0) begin failures++; $display("FAIL badch_flags: got %b expected 00000", ch_calibrated_5); end
      cal_start_5 = 1'b1; cal_ch_5 = 3'd4; cal_max_abs_5 = 32'd127;
      @(posedge clk); n = 1;
      @(negedge clk); cal_start_5 = 1'b0;
      while (!cal_done_5 && n < 200) begin @(posedge clk); n++; @(negedge clk); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (ch_calibrated_5 !== 5'b10000) begin failures++; $display("FAIL lastch_flags: got %b expected 10000", ch_calibrated_5); end
      checks++; if (dbg_scale_5 !== 32'(ref_scale(127))) begin failures++; $display("FAIL lastch_scale: got %0d expected %0d", dbg_scale_5, ref_scale(127)); end
   endtask

   task automatic test_backpressure();
      st_data.delete(); st_ch.delete(); st_rdy.delete();
      for (int i = 0; i < 12; i++) begin
         st_data.push_back(int'($urandom_range(0, 4000)) - 2000);
         st_ch.push_back(int'($urandom_range(0, 1)));
      end
      for (int c = 0; c < 20; c++) st_rdy.push_back(!(c >= 3 && c < 8));
      run_stream(100);
      check_stream("bp");
      checks++; if (stall_cycles < 1) begin failures++; $display("FAIL bp_in_ready_low: got %0d stalled cycles expected >0", stall_cycles); end
      checks++; if (hold_err !== 0) begin failures++; $display("FAIL bp_hold_stable: got %0d changes expected 0", hold_err); end
   endtask

   task automatic test_random_stream();
      int n; bit e; int m;
      m = int'($urandom_range(1, 5000));
      do_cal(2, 32'(m), n, e);
      model_scale[2] = ref_scale(longint'(m)); model_cal[2] = 1'b1;
      checks++; if (dbg_scale !== 32'(model_scale[2])) begin failures++; $display("FAIL rnd_cal_scale: got %0d expected %0d", dbg_scale, model_scale[2]); end
      st_data.delete(); st_ch.delete(); st_rdy.delete();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) st_data.push_back(int'($urandom));
         else st_data.push_back(int'($urandom_range(0, 4000)) - 2000);
         st_ch.push_back(int'($urandom_range(0, 3)));
      end
      for (int c = 0; c < 100; c++) st_rdy.push_back($urandom_range(0, 3) != 0);
      run_stream(300);
      check_stream("rnd");
      checks++; if (hold_err !== 0) begin failures++; $display("FAIL rnd_hold_stable: got %0d changes expected 0", hold_err); end
   endtask

   task automatic test_recal();
      int n; bit e;
      do_cal(0, 32'd50, n, e);
      model_scale[0] = ref_scale(50);
      checks++; if (dbg_scale !== 32'(model_scale[0])) begin failures++; $display("FAIL recal_scale: got %0d expected %0d", dbg_scale, model_scale[0]); end
      checks++; if (ch_calibrated !== model_flags()) begin failures++; $display("FAIL recal_flags: got %b expected %b", ch_calibrated, model_flags()); end
   endtask

   task automatic test_reset_mid_div();
      int n; bit e;
      @(negedge clk); cal_start = 1'b1; cal_ch = 2'd3; cal_max_abs = 32'd7;
      @(posedge clk);
      @(negedge clk); cal_start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checks++; if (cal_busy !== 1'b1) begin failures++; $display("FAIL middiv_busy: got %0b expected 1", cal_busy); end
      reset_n = 1'b0;
      clear_model();
      #1;
      checks++; if (cal_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b expected 0", cal_busy); end
      checks++; if (ch_calibrated !== '0) begin failures++; $display("FAIL rst_flags: got %b expected 0", ch_calibrated); end
      checks++; if (dbg_scale !== 32'd0) begin failures++; $display("FAIL rst_scale: got %0d expected 0", dbg_scale); end
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
      do_cal(3, 32'd7, n, e);
      model_scale[3] = ref_scale(7); model_cal[3] = 1'b1;
      checks++; if (n !== 32) begin failures++; $display("FAIL rst_recal_latency: got %0d expected 32", n); end
      checks++; if (ch_calibrated !== model_flags()) begin failures++; $display("FAIL rst_recal_flags: got %b expected %b", ch_calibrated, model_flags()); end
      checks++; if (dbg_scale !== 32'(model_scale[3])) begin failures++; $display("FAIL rst_recal_scale: got %0d expected %0d", dbg_scale, model_scale[3]); end
   endtask

   initial begin
      cal_start = 1'b0; cal_ch = '0; cal_max_abs = '0;
      in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
      cal_start_5 = 1'b0; cal_ch_5 = '0; cal_max_abs_5 = '0;
      in_valid_5 = 1'b0; in_data_5 = '0; in_ch_5 = '0; out_ready_5 = 1'b1;
      reset_n = 1'b1;
      clear_model();
      @(negedge clk);
      test_reset();
      test_calibrate_ch0();
      test_stream_basic();
      test_saturation();
      test_interleave_ch1();
      test_cal_errors();
      test_bad_channel();
      test_backpressure();
      test_random_stream();
      test_recal();
      test_reset_mid_div();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
